adc_scan_sched: RTL

//  Multi-channel conversion scheduler for the serial ADC frame engine. Runs a periodic sweep over a

---
 rtl/adc_scan_sched.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/adc_scan_sched.sv
// Conversion scheduler: periodic channel sweeps, one-shot software
// conversions, per-channel result registers and a stall watchdog.
module adc_scan_sched #(
  parameter int NCH     = 8,
  parameter int CHW     = 3,
  parameter int DW      = 10,
  parameter int PERIOD  = 4096,
  parameter int TIMEOUT = 8192
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           scan_en,
  input  logic [NCH-1:0] ch_mask,
  input  logic           sw_req,
  input  logic [CHW-1:0] sw_ch,
  output logic           sw_done,
  output logic           cnv_start,
  output logic [CHW-1:0] cnv_ch,
  input  logic           cnv_busy,
  input  logic           cnv_done,
  input  logic [DW-1:0]  cnv_data,
  input  logic [CHW-1:0] rd_ch,
  output logic [DW-1:0]  rd_data,
  output logic           rd_valid,
  output logic           scan_done,
  output logic           timeout
);

  localparam int PW = $clog2(PERIOD);
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT_DONE, STORE
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  per_q, per_d;
  logic [WW-1:0]  wdog_q, wdog_d;
  logic           scan_pend_q, scan_pend_d;
  logic           sw_pend_q, sw_pend_d;
  logic [CHW-1:0] sw_ch_q, sw_ch_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [CHW-1:0] pos_q, pos_d;
  logic           is_sw_q, is_sw_d;
  logic           sweep_q, sweep_d;
  logic           wr_q, wr_d;
  logic [DW-1:0]  data_q, data_d;
  logic [DW-1:0]  res_q [NCH];
  logic [DW-1:0]  res_d [NCH];
  logic [NCH-1:0] valid_q, valid_d;
  logic [DW-1:0]  rd_data_q, rd_data_d;
  logic           rd_valid_q, rd_valid_d;

  logic           tick;
  logic           pend_clr;
  logic [CHW:0]   f_lo;
  logic [CHW:0]   f_nx;

  // {found, index} of the lowest set bit of m at or above lo
  function automatic logic [CHW:0] first_from(
    input logic [NCH-1:0] m,
    input int             lo
  );
    logic [CHW:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (i >= lo && m[i]) r = {1'b1, CHW'(i)};
    end
    return r;
  endfunction

  assign cnv_ch   = ch_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    sw_pend_d   = sw_pend_q;
    sw_ch_d     = sw_ch_q;
    mask_d      = mask_q;
    ch_d        = ch_q;
    pos_d       = pos_q;
    is_sw_d     = is_sw_q;
    sweep_d     = sweep_q;
    wr_d        = wr_q;
    data_d      = data_q;
    res_d       = res_q;
    valid_d     = valid_q;
    pend_clr    = 1'b0;
    sw_done     = 1'b0;
    cnv_start   = 1'b0;
    scan_done   = 1'b0;
    timeout     = 1'b0;
    f_lo        = first_from(ch_mask, 0);
    f_nx        = first_from(mask_q, int'(pos_q) + 1);

    tick  = scan_en && (per_q == PW'(PERIOD - 1));
    per_d = '0;
    if (scan_en && !tick) per_d = per_q + 1'b1;

    if (sw_req && !sw_pend_q) begin
      sw_pend_d = 1'b1;
      sw_ch_d   = sw_ch;
    end

    unique case (state_q)
      IDLE: begin
        if (sw_pend_q) begin
          ch_d    = sw_ch_q;
          is_sw_d = 1'b1;
          sweep_d = 1'b0;
          state_d = ISSUE;
        end else if (scan_pend_q && scan_en) begin
          pend_clr = 1'b1;
          if (|ch_mask) begin
            mask_d  = ch_mask;
            ch_d    = f_lo[CHW-1:0];
            pos_d   = f_lo[CHW-1:0];
            is_sw_d = 1'b0;
            sweep_d = 1'b1;
            state_d = ISSUE;
          end else begin
            scan_done = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (!cnv_busy) begin
          cnv_start = 1'b1;
          wdog_d    = '0;
          state_d   = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (cnv_done) begin
          data_d  = cnv_data;
          wr_d    = 1'b1;
          state_d = STORE;
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          wr_d    = 1'b0;
          state_d = STORE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      STORE: begin
        if (wr_q) begin
          res_d[ch_q]   = data_q;
          valid_d[ch_q] = 1'b1;
        end
        if (is_sw_q) begin
          sw_done   = 1'b1;
          sw_pend_d = 1'b0;
        end
        // a pending software op pre-empts the rest of the sweep
        if (sw_pend_q && !is_sw_q) begin
          ch_d    = sw_ch_q;
          is_sw_d = 1'b1;
          state_d = ISSUE;
        end else if (sweep_q && scan_en && f_nx[CHW]) begin
          ch_d    = f_nx[CHW-1:0];
          pos_d   = f_nx[CHW-1:0];
          is_sw_d = 1'b0;
          state_d = ISSUE;
        end else begin
          scan_done = sweep_q && scan_en;
          sweep_d   = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    scan_pend_d = scan_en && (tick || (scan_pend_q && !pend_clr));
    rd_data_d   = res_q[rd_ch];
    rd_valid_d  = valid_q[rd_ch];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      per_q       <= '0;
      wdog_q      <= '0;
      scan_pend_q <= 1'b0;
      sw_pend_q   <= 1'b0;
      sw_ch_q     <= '0;
      mask_q      <= '0;
      ch_q        <= '0;
      pos_q       <= '0;
      is_sw_q     <= 1'b0;
      sweep_q     <= 1'b0;
      wr_q        <= 1'b0;
      data_q      <= '0;
      for (int i = 0; i < NCH; i++) res_q[i] <= '0;
      valid_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_q       <= per_d;
      wdog_q      <= wdog_d;
      scan_pend_q <= scan_pend_d;
      sw_pend_q   <= sw_pend_d;
      sw_ch_q     <= sw_ch_d;
      mask_q      <= mask_d;
      ch_q        <= ch_d;
      pos_q       <= pos_d;
      is_sw_q     <= is_sw_d;
      sweep_q     <= sweep_d;
      wr_q        <= wr_d;
      data_q      <= data_d;
      res_q       <= res_d;
      valid_q     <= valid_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

endmodule
